// File: rtl/lab22_parity_rx.sv
// rtl/lab22_parity_rx.sv - serial receiver with XOR parity check for the lab parity link
// Optional macro LAB22_ODD_PARITY_EN selects odd parity (default is even parity).
module lab22_parity_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_W - 1);

`ifdef LAB22_ODD_PARITY_EN
  localparam logic EXP_PAR = 1'b1;
`else
  localparam logic EXP_PAR = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q;
  logic              rx_meta_q;
  logic              rx_s_q;
  logic [CW-1:0]     baud_q;
  logic [IW-1:0]     bit_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic              xor_q;
  logic              pbit_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              parity_err_q;
  logic              frame_err_q;
  logic              busy_q;

  // Line is idle high, so the synchroniser resets to 1 to avoid a phantom start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // LSB arrives first, so each new bit enters at the MSB and earlier bits move down.
  always_comb begin
    shift_d             = shift_q >> 1;
    shift_d[DATA_W-1]   = rx_s_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      xor_q        <= 1'b0;
      pbit_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            baud_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (baud_q == HALF_LAST) begin
            baud_q <= '0;
            if (!rx_s_q) begin
              state_q   <= S_DATA;
              bit_idx_q <= '0;
              xor_q     <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q    <= '0;
            shift_q   <= shift_d;
            xor_q     <= xor_q ^ rx_s_q;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == BIT_LAST) begin
              state_q <= S_PARITY;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            pbit_q  <= rx_s_q;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q       <= '0;
            data_q       <= shift_q;
            parity_err_q <= (xor_q ^ pbit_q) != EXP_PAR;
            frame_err_q  <= ~rx_s_q;
            valid_q      <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lab22_parity_rx.sv
// tb/tb_lab22_parity_rx.sv - directed self-checking bench for lab22_parity_rx
module tb_lab22_parity_rx;

  localparam int CPB = 4;
  localparam int DW  = 8;

`ifdef LAB22_ODD_PARITY_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          rx;
  logic [DW-1:0] data;
  logic          valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  int n_checks;
  int n_fail;
  int vcount;
  logic [DW-1:0] vdata_q[$];
  logic          verr_q[$];

  lab22_parity_rx #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount <= vcount + 1;
      vdata_q.push_back(data);
      verr_q.push_back(parity_err | frame_err);
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(100);
    @(negedge clk);
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b want 0", parity_err); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (vcount !== 0) begin n_fail++; $display("FAIL reset_vcount got %0d want 0", vcount); end
  endtask

  task automatic test_good_frame;
    int base;
    base = vcount;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(12);
    @(negedge clk);
    n_checks++; if (vcount !== base + 1) begin n_fail++; $display("FAIL a5_vcount got %0d want %0d", vcount, base + 1); end
    n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL a5_data got %h want a5", data); end
    n_checks++; if (parity_err !== ODD) begin n_fail++; $display("FAIL a5_perr got %b want %b", parity_err, ODD); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL a5_ferr got %b want 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL a5_busy got %b want 0", busy); end
  endtask

  task automatic test_parity_error;
    int base;
    base = vcount;
    send_frame(8'h07, 1'b0, 1'b1);
    idle(12);
    @(negedge clk);
    n_checks++; if (vcount !== base + 1) begin n_fail++; $display("FAIL 07_vcount got %0d want %0d", vcount, base + 1); end
    n_checks++; if (data !== 8'h07) begin n_fail++; $display("FAIL 07_data got %h want 07", data); end
    n_checks++; if (parity_err !== ~ODD) begin n_fail++; $display("FAIL 07_perr got %b want %b", parity_err, ~ODD); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL 07_ferr got %b want 0", frame_err); end
  endtask

  task automatic test_frame_error;
    int base;
    base = vcount;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(16);
    @(negedge clk);
    n_checks++; if (vcount !== base + 1) begin n_fail++; $display("FAIL 3c_vcount got %0d want %0d", vcount, base + 1); end
    n_checks++; if (data !== 8'h3C) begin n_fail++; $display("FAIL 3c_data got %h want 3c", data); end
    n_checks++; if (parity_err !== ODD) begin n_fail++; $display("FAIL 3c_perr got %b want %b", parity_err, ODD); end
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL 3c_ferr got %b want 1", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL 3c_busy got %b want 0", busy); end
  endtask

  task automatic test_false_start;
    int base;
    base = vcount;
    rx = 1'b0;
    @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start got %b want 1", busy); end
    idle(12);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end got %b want 0", busy); end
    n_checks++; if (vcount !== base) begin n_fail++; $display("FAIL glitch_vcount got %0d want %0d", vcount, base); end
    n_checks++; if (data !== 8'h3C) begin n_fail++; $display("FAIL glitch_data got %h want 3c", data); end
  endtask

  task automatic test_reset_mid_frame;
    int base;
    base = vcount;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(60);
    @(negedge clk);
    n_checks++; if (vcount !== base) begin n_fail++; $display("FAIL rstmid_vcount got %0d want %0d", vcount, base); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got %h want 00", data); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_ferr got %b want 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    send_frame(8'h81, 1'b0, 1'b1);
    idle(12);
    @(negedge clk);
    n_checks++; if (vcount !== base + 1) begin n_fail++; $display("FAIL 81_vcount got %0d want %0d", vcount, base + 1); end
    n_checks++; if (data !== 8'h81) begin n_fail++; $display("FAIL 81_data got %h want 81", data); end
    n_checks++; if (parity_err !== ODD) begin n_fail++; $display("FAIL 81_perr got %b want %b", parity_err, ODD); end
  endtask

  task automatic test_back_to_back;
    int base;
    base = vcount;
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    idle(12);
    @(negedge clk);
    n_checks++; if (vcount !== base + 2) begin n_fail++; $display("FAIL b2b_vcount got %0d want %0d", vcount, base + 2); end
    if (vcount == base + 2) begin
      n_checks++; if (vdata_q[base] !== 8'h12) begin n_fail++; $display("FAIL b2b_data0 got %h want 12", vdata_q[base]); end
      n_checks++; if (vdata_q[base+1] !== 8'h34) begin n_fail++; $display("FAIL b2b_data1 got %h want 34", vdata_q[base+1]); end
      n_checks++; if (verr_q[base] !== ODD) begin n_fail++; $display("FAIL b2b_err0 got %b want %b", verr_q[base], ODD); end
      n_checks++; if (verr_q[base+1] !== ODD) begin n_fail++; $display("FAIL b2b_err1 got %b want %b", verr_q[base+1], ODD); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vcount   = 0;
    rst_n    = 1'b0;
    rx       = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_frame_error();
    test_false_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
